sam_mouse_port: RTL and testbench

SAM_MOUSE_PORT -- requirements
Module: sam_mouse_port

---
 rtl/sam_mouse_pkg.sv | 32 +++
 rtl/sam_mouse_port_packet_asm.sv | 82 ++++++++
 rtl/sam_mouse_port.sv | 128 ++++++++++++
 tb/tb_sam_mouse_port.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/sam_mouse_pkg.sv
// Shared constants and types for the SAM mouse port: read-sequence indices,
// the header nibble, the packet length and the byte-counter state encoding.
package sam_mouse_pkg;

  localparam logic [3:0] IDX_HDR  = 4'd0;
  localparam logic [3:0] IDX_BTN  = 4'd1;
  localparam logic [3:0] IDX_Y_HI = 4'd2;
  localparam logic [3:0] IDX_Y_MD = 4'd3;
  localparam logic [3:0] IDX_Y_LO = 4'd4;
  localparam logic [3:0] IDX_X_HI = 4'd5;
  localparam logic [3:0] IDX_X_MD = 4'd6;
  localparam logic [3:0] IDX_X_LO = 4'd7;
  localparam logic [3:0] IDX_TRL  = 4'd8;

  localparam logic [3:0] HDR_NIBBLE = 4'hF;

  localparam int         PKT_BYTES = 3;
  localparam logic [1:0] PKT_LAST  = 2'(PKT_BYTES - 1);

  typedef enum logic [1:0] {
    PKT_B0 = 2'd0,
    PKT_B1 = 2'd1,
    PKT_B2 = PKT_LAST
  } pkt_state_t;

  typedef struct packed {
    logic m;
    logic r;
    logic l;
  } btn_t;

endpackage

// File: rtl/sam_mouse_port_packet_asm.sv
// PS/2 3-byte packet assembler: resyncs on the byte0 bit3 marker, emits
// overflow-filtered dx/dy and buttons with a one-cycle valid after byte2.
import sam_mouse_pkg::*;

module mouse_packet_asm (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ps2_byte,
  input  logic       ps2_byte_valid,
  output logic [8:0] dx,
  output logic [8:0] dy,
  output btn_t       buttons,
  output logic       pkt_vld,
  output logic       pkt_err
);

  pkt_state_t st;
  pkt_state_t st_nx;
  logic [7:0] b0_q;
  logic [7:0] b1_q;
  logic       ld_b0;
  logic       ld_b1;
  logic       fire;
  logic       bad_hdr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) st <= PKT_B0;
    else     st <= st_nx;
  end

  always_comb begin
    st_nx = st;
    case (st)
      PKT_B0:  if (ps2_byte_valid && ps2_byte[3]) st_nx = PKT_B1;
      PKT_B1:  if (ps2_byte_valid) st_nx = PKT_B2;
      PKT_B2:  if (ps2_byte_valid) st_nx = PKT_B0;
      default: st_nx = PKT_B0;
    endcase
  end

  always_comb begin
    ld_b0   = 1'b0;
    ld_b1   = 1'b0;
    fire    = 1'b0;
    bad_hdr = 1'b0;
    if (ps2_byte_valid) begin
      case (st)
        PKT_B0: begin
          ld_b0   = ps2_byte[3];
          bad_hdr = ~ps2_byte[3];
        end
        PKT_B1:  ld_b1 = 1'b1;
        PKT_B2:  fire  = 1'b1;
        default: ;
      endcase
    end
  end

  // Overflowed axes are delivered as zero so the accumulator sees no motion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b0_q    <= '0;
      b1_q    <= '0;
      dx      <= '0;
      dy      <= '0;
      buttons <= '0;
      pkt_vld <= 1'b0;
      pkt_err <= 1'b0;
    end else begin
      pkt_vld <= fire;
      pkt_err <= bad_hdr;
      if (ld_b0) b0_q <= ps2_byte;
      if (ld_b1) b1_q <= ps2_byte;
      if (fire) begin
        dx      <= b0_q[6] ? 9'd0 : {b0_q[4], b1_q};
        dy      <= b0_q[7] ? 9'd0 : {b0_q[5], ps2_byte};
        buttons <= b0_q[2:0];
      end
    end
  end

endmodule

// File: rtl/sam_mouse_port.sv
// SAM Coupe mouse port: packet accumulation plus the nibble read sequencer on 0xFFFE.
// MOUSE_SATURATE_EN selects saturating accumulators; undefined, they wrap.
import sam_mouse_pkg::*;

module sam_mouse_port #(
  parameter int TIMEOUT_CYCLES = 600,
  parameter int ACC_W          = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ps2_byte,
  input  logic       ps2_byte_valid,
  input  logic       rdmsel,
  output logic [3:0] mdata,
  output logic       pkt_err
);

  localparam int           TW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);

  logic [8:0]       dx;
  logic [8:0]       dy;
  btn_t             pkt_btn;
  logic             pkt_vld;
  btn_t             btn_q;
  btn_t             snap_btn;
  logic [ACC_W-1:0] acc_x;
  logic [ACC_W-1:0] acc_y;
  logic [ACC_W-1:0] snap_x;
  logic [ACC_W-1:0] snap_y;
  logic [ACC_W-1:0] base_x;
  logic [ACC_W-1:0] base_y;
  logic [3:0]       idx;
  logic             rd_q;
  logic [TW-1:0]    tcnt;
  logic             rd_fall;
  logic             rd_edge;
  logic             snap_fire;
  logic [11:0]      view_x;
  logic [11:0]      view_y;

  mouse_packet_asm u_asm (
    .clk            (clk),
    .rst            (rst),
    .ps2_byte       (ps2_byte),
    .ps2_byte_valid (ps2_byte_valid),
    .dx             (dx),
    .dy             (dy),
    .buttons        (pkt_btn),
    .pkt_vld        (pkt_vld),
    .pkt_err        (pkt_err)
  );

  function automatic logic [ACC_W-1:0] acc_next(input logic [ACC_W-1:0] base,
                                                input logic [8:0]       d);
    logic [ACC_W-1:0] ext;
    logic [ACC_W-1:0] sum;
    ext = {{(ACC_W-9){d[8]}}, d};
    sum = base + ext;
`ifdef MOUSE_SATURATE_EN
    if ((base[ACC_W-1] == ext[ACC_W-1]) && (sum[ACC_W-1] != base[ACC_W-1]))
      sum = base[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
`endif
    return sum;
  endfunction

  assign rd_fall   = rd_q & ~rdmsel;
  assign rd_edge   = rd_q ^ rdmsel;
  assign snap_fire = rd_fall && (idx == IDX_HDR);

  // A snapshot clear and an accumulate in the same cycle: the delta seeds the cleared accumulator.
  assign base_x = snap_fire ? '0 : acc_x;
  assign base_y = snap_fire ? '0 : acc_y;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_x    <= '0;
      acc_y    <= '0;
      btn_q    <= '0;
      snap_x   <= '0;
      snap_y   <= '0;
      snap_btn <= '0;
    end else begin
      acc_x <= pkt_vld ? acc_next(base_x, dx) : base_x;
      acc_y <= pkt_vld ? acc_next(base_y, dy) : base_y;
      if (pkt_vld) btn_q <= pkt_btn;
      if (snap_fire) begin
        snap_x   <= acc_x;
        snap_y   <= acc_y;
        snap_btn <= btn_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q <= 1'b0;
      tcnt <= '0;
      idx  <= IDX_HDR;
    end else begin
      rd_q <= rdmsel;
      if (rd_edge)           tcnt <= '0;
      else if (tcnt != TMAX) tcnt <= tcnt + 1'b1;
      if (rd_fall)           idx <= (idx == IDX_TRL) ? IDX_HDR : idx + 4'd1;
      else if (tcnt == TMAX) idx <= IDX_HDR;
    end
  end

  assign view_x = snap_x[11:0];
  assign view_y = snap_y[11:0];

  always_comb begin
    mdata = HDR_NIBBLE;
    case (idx)
      IDX_HDR:  mdata = HDR_NIBBLE;
      IDX_BTN:  mdata = {1'b1, ~snap_btn.m, ~snap_btn.r, ~snap_btn.l};
      IDX_Y_HI: mdata = view_y[11:8];
      IDX_Y_MD: mdata = view_y[7:4];
      IDX_Y_LO: mdata = view_y[3:0];
      IDX_X_HI: mdata = view_x[11:8];
      IDX_X_MD: mdata = view_x[7:4];
      IDX_X_LO: mdata = view_x[3:0];
      IDX_TRL:  mdata = HDR_NIBBLE;
      default:  mdata = HDR_NIBBLE;
    endcase
  end

endmodule

// File: tb/tb_sam_mouse_port.sv
// Directed bench for sam_mouse_port: packet decode, read sequence, resync,
// timeout, snapshot/accumulate collision, accumulator overflow and reset.
module tb_sam_mouse_port;

  localparam int TO = 600;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] ps2_byte;
  logic       ps2_byte_valid;
  logic       rdmsel;
  logic [3:0] mdata;
  logic       pkt_err;

  int checks   = 0;
  int errors   = 0;
  int err_seen = 0;
  logic [3:0] nib;

  sam_mouse_port #(.TIMEOUT_CYCLES(TO), .ACC_W(12)) dut (
    .clk            (clk),
    .rst            (rst),
    .ps2_byte       (ps2_byte),
    .ps2_byte_valid (ps2_byte_valid),
    .rdmsel         (rdmsel),
    .mdata          (mdata),
    .pkt_err        (pkt_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    ps2_byte       = b;
    ps2_byte_valid = 1'b1;
    @(negedge clk);
    ps2_byte_valid = 1'b0;
    if (pkt_err) err_seen++;
  endtask

  task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    send_byte(b0);
    send_byte(b1);
    send_byte(b2);
  endtask

  task automatic rd(output logic [3:0] n);
    @(negedge clk);
    rdmsel = 1'b1;
    @(negedge clk);
    n      = mdata;
    rdmsel = 1'b0;
    @(negedge clk);
  endtask

  // Expected nibbles are consumed from the top of exp, one per read.
  task automatic read_seq(input string tag, input int n, input logic [35:0] exp);
    logic [3:0] got;
    for (int i = 0; i < n; i++) begin
      rd(got);
      chk($sformatf("%s[%0d]", tag, i), {8'd0, got}, {8'd0, exp[35-4*i -: 4]});
    end
  endtask

  initial begin
    rst            = 1'b1;
    ps2_byte       = 8'h00;
    ps2_byte_valid = 1'b0;
    rdmsel         = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_mdata", {8'd0, mdata}, 12'h00F);
    chk("reset_err", {11'd0, pkt_err}, 12'h000);
    rst = 1'b0;

    // L pressed, X=+5, byte2 0xFD with Y sign clear reads as +253.
    send_pkt(8'h09, 8'h05, 8'hFD);
    read_seq("pkt09", 9, 36'hFE0FD005F);
    // Y sign bit set: the same byte2 reads as -3.
    send_pkt(8'h29, 8'h05, 8'hFD);
    read_seq("pkt29", 9, 36'hFEFFD005F);
    chk("no_err_clean", 12'(err_seen), 12'd0);

    err_seen = 0;
    send_byte(8'h00);
    send_pkt(8'h08, 8'h00, 8'h00);
    chk("resync_err", 12'(err_seen), 12'd1);
    read_seq("resync", 9, 36'hFF000000F);

    send_pkt(8'h48, 8'h10, 8'h05);
    read_seq("xovf", 9, 36'hFF005000F);

    rd(nib);
    chk("to_idx0", {8'd0, nib}, 12'h00F);
    rd(nib);
    chk("to_idx1", {8'd0, nib}, 12'h00F);
    repeat (TO + 1) @(negedge clk);
    rd(nib);
    chk("timeout_hdr", {8'd0, nib}, 12'h00F);
    repeat (TO + 1) @(negedge clk);

    // byte2 is taken while rdmsel is high and its accumulate lands on the idx0 falling edge.
    send_pkt(8'h08, 8'h07, 8'h00);
    err_seen = 0;
    send_byte(8'h08);
    send_byte(8'h03);
    @(negedge clk);
    rdmsel         = 1'b1;
    ps2_byte       = 8'h00;
    ps2_byte_valid = 1'b1;
    @(negedge clk);
    chk("coll_hdr", {8'd0, mdata}, 12'h00F);
    ps2_byte_valid = 1'b0;
    rdmsel         = 1'b0;
    @(negedge clk);
    read_seq("coll_old", 8, 36'hF000007F0);
    read_seq("coll_new", 9, 36'hFF000003F);
    chk("coll_err", 12'(err_seen), 12'd0);

    for (int p = 0; p < 20; p++) send_pkt(8'h08, 8'hFF, 8'h00);
`ifdef MOUSE_SATURATE_EN
    read_seq("sat", 9, 36'hFF0007FFF);
`else
    read_seq("wrap", 9, 36'hFF0003ECF);
`endif

    send_byte(8'h08);
    send_byte(8'h05);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_mdata", {8'd0, mdata}, 12'h00F);
    chk("midrst_err", {11'd0, pkt_err}, 12'h000);
    rst      = 1'b0;
    err_seen = 0;
    send_byte(8'h05);
    chk("midrst_resync", 12'(err_seen), 12'd1);
    send_pkt(8'h08, 8'h01, 8'h00);
    read_seq("midrst", 9, 36'hFF000001F);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
